// File: rtl/puf_challenge_ctrl.sv
// puf_challenge_ctrl: arbiter-PUF challenge sequencer (clear, race, sample, respond).
// Define PUF_MAJORITY_EN to evaluate each challenge REPEAT times and report the majority.
module puf_challenge_ctrl #(
    parameter int N          = 128,
    parameter int CLEAR_CYC  = 2,
    parameter int SETTLE_CYC = 4,
    parameter int REPEAT     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [N-1:0] chal_data,
    output logic [N-1:0] puf_sel,
    output logic         puf_in,
    output logic         puf_reset,
    input  logic         puf_out,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_bit,
    output logic [7:0]   resp_ones
);
`ifdef PUF_MAJORITY_EN
    localparam int EVALS = REPEAT;
`else
    localparam int EVALS = 1;
`endif
    localparam logic [7:0] CLR_LAST  = 8'(CLEAR_CYC - 1);
    localparam logic [7:0] SET_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] EVAL_LAST = 8'(EVALS - 1);
    localparam logic [7:0] HALF      = 8'(EVALS / 2);
    if (CLEAR_CYC < 1 || CLEAR_CYC > 255) begin : g_bad_clear
        $error("CLEAR_CYC must be 1..255");
    end
    if (SETTLE_CYC < 2 || SETTLE_CYC > 255) begin : g_bad_settle
        $error("SETTLE_CYC must be 2..255");
    end
`ifdef PUF_MAJORITY_EN
    if (REPEAT < 1 || REPEAT > 255 || REPEAT % 2 == 0) begin : g_bad_repeat
        $error("REPEAT must be odd and 1..255");
    end
`endif
    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, SAMPLE, DONE} state_t;
    state_t     state, state_nxt;
    logic [7:0] cyc, evals, ones, ones_nxt;
    logic [1:0] sync;
    logic       ready_q;
    logic       accept;
    assign accept   = state == IDLE && chal_valid && chal_ready;
    assign ones_nxt = ones + {7'd0, sync[1]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? CLEAR : IDLE;
            CLEAR:   state_nxt = cyc == CLR_LAST ? SETTLE : CLEAR;
            SETTLE:  state_nxt = cyc == SET_LAST ? SAMPLE : SETTLE;
            SAMPLE:  state_nxt = evals == EVAL_LAST ? DONE : CLEAR;
            DONE:    state_nxt = resp_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        puf_in     = state == SETTLE || state == SAMPLE;
        puf_reset  = !(state == SETTLE || state == SAMPLE);
        resp_valid = state == DONE;
        chal_ready = ready_q;
        resp_ones  = ones;
    end
    // ready is registered so it stays low while reset is held and rises on the first edge after
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q  <= 1'b0;
            sync     <= 2'b00;
            cyc      <= 8'd0;
            evals    <= 8'd0;
            ones     <= 8'd0;
            puf_sel  <= '0;
            resp_bit <= 1'b0;
        end else begin
            ready_q <= state_nxt == IDLE;
            sync    <= {sync[0], puf_out};
            cyc     <= state_nxt != state ? 8'd0 : cyc + 8'd1;
            puf_sel <= accept ? chal_data : puf_sel;
            evals   <= accept ? 8'd0 : state == SAMPLE ? evals + 8'd1 : evals;
            ones    <= accept ? 8'd0 : state == SAMPLE ? ones_nxt : ones;
            resp_bit <= state == SAMPLE && evals == EVAL_LAST ? ones_nxt > HALF : resp_bit;
        end
    end
endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb_puf_challenge_ctrl: scoreboard bench for puf_challenge_ctrl with a scripted puf_out model.
module tb_puf_challenge_ctrl;
    localparam int N = 128;
    localparam int CLR = 2;
    localparam int SET = 4;
`ifdef PUF_MAJORITY_EN
    localparam bit VOTE = 1'b1;
    localparam int EV = 5;
`else
    localparam bit VOTE = 1'b0;
    localparam int EV = 1;
`endif
    localparam int LAT = EV * (CLR + SET + 1);
    logic         clk = 1'b0, reset, chal_valid, chal_ready, puf_in, puf_reset, puf_out = 1'b0;
    logic         resp_valid, resp_ready, resp_bit;
    logic [N-1:0] chal_data, puf_sel;
    logic [7:0]   resp_ones;
    typedef struct {logic b; logic [7:0] o; logic [N-1:0] sel;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, hs_cyc = -10, eidx = 0;
    logic [0:4] pat = 5'b00000;
    puf_challenge_ctrl #(.N(N), .CLEAR_CYC(CLR), .SETTLE_CYC(SET), .REPEAT(5)) dut (
        .clk(clk), .reset(reset), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_data(chal_data), .puf_sel(puf_sel), .puf_in(puf_in), .puf_reset(puf_reset),
        .puf_out(puf_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bit(resp_bit), .resp_ones(resp_ones)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    // puf_out model: evaluation k of a challenge races to pat[k]
    logic prev_in = 1'b0;
    always @(negedge clk) begin
        if (reset || chal_ready) eidx = 0;
        else if (prev_in && !puf_in) eidx = eidx + 1;
        prev_in = puf_in;
        puf_out = (puf_in && eidx < 5) ? pat[eidx] : 1'b0;
    end
    logic prev_rv = 1'b0, prev_bit = 1'b0, prev_hs = 1'b0;
    logic [7:0] prev_ones = 8'd0;
    int n_rst = 0, n_in = 0;
    exp_t e;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            n_rst = 0;
            n_in = 0;
            prev_rv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_rv && !prev_hs) begin
                chk("hold_valid", N'(resp_valid), N'(1));
                chk("hold_bit", N'(resp_bit), N'(prev_bit));
                chk("hold_ones", N'(resp_ones), N'(prev_ones));
            end
            if (sb.size() > 0 && !chal_ready) chk("puf_sel", puf_sel, sb[0].sel);
            if (sb.size() > 0 && !chal_ready && !resp_valid) begin
                n_rst += int'(puf_reset);
                n_in += int'(puf_in);
            end
            if (resp_valid && !prev_rv) begin
                chk("latency", N'(cyc - acc_cyc), N'(LAT));
                chk("puf_reset_cycles", N'(n_rst), N'(EV * CLR));
                chk("puf_in_cycles", N'(n_in), N'(EV * (SET + 1)));
                n_rst = 0;
                n_in = 0;
            end
            if (resp_valid) chk("ready_in_done", N'(chal_ready), N'(0));
            prev_hs = resp_valid && resp_ready;
            if (prev_hs) begin
                hs_cyc = cyc + 1;
                if (sb.size() == 0) chk("unexpected_resp", N'(1), N'(sb.size()));
                else begin
                    e = sb.pop_front();
                    chk("resp_bit", N'(resp_bit), N'(e.b));
                    chk("resp_ones", N'(resp_ones), N'(e.o));
                end
            end
            prev_rv = resp_valid;
            prev_bit = resp_bit;
            prev_ones = resp_ones;
        end
    end
    task automatic send(input logic [N-1:0] d, input logic b, input logic [7:0] o);
        int k = 0;
        @(negedge clk);
        chal_valid = 1'b1;
        chal_data = d;
        while (!chal_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!chal_ready) chk("accept_timeout", N'(chal_ready), N'(1));
        else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            sb.push_back('{b, o, d});
        end
    endtask
    task automatic wait_done();
        int k = 0;
        while (sb.size() > 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) chk("resp_timeout", N'(sb.size()), N'(0));
    endtask
    initial begin
        int k;
        reset = 1'b1;
        chal_valid = 1'b0;
        chal_data = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", N'(chal_ready), N'(0));
        chk("rst_puf_reset", N'(puf_reset), N'(1));
        chk("rst_puf_in", N'(puf_in), N'(0));
        chk("rst_valid", N'(resp_valid), N'(0));
        chk("rst_bit", N'(resp_bit), N'(0));
        chk("rst_ones", N'(resp_ones), N'(0));
        chk("rst_sel", puf_sel, '0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", N'(chal_ready), N'(1));
        pat = 5'b10110;
        send({16{8'hA5}}, 1'b1, VOTE ? 8'd3 : 8'd1);
        chal_valid = 1'b0;
        wait_done();
        pat = 5'b00000;
        send({4{32'h1234_5678}}, 1'b0, 8'd0);
        chal_valid = 1'b0;
        wait_done();
        pat = 5'b01101;
        send({4{32'hDEAD_BEEF}}, VOTE, VOTE ? 8'd3 : 8'd0);
        k = 0;
        while (!resp_valid && k < 500) begin
            @(negedge clk);
            chal_data = ~chal_data;
            chal_valid = ~chal_valid;
            k++;
        end
        chal_valid = 1'b0;
        wait_done();
        resp_ready = 1'b0;
        pat = 5'b11000;
        send({8{16'hC3C3}}, !VOTE, VOTE ? 8'd2 : 8'd1);
        chal_data = {8{16'h5A5A}};
        k = 0;
        while (!resp_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("done_block_ready", N'(chal_ready), N'(0));
        end
        resp_ready = 1'b1;
        send({8{16'h5A5A}}, !VOTE, VOTE ? 8'd2 : 8'd1);
        chk("accept_after_hs", N'(acc_cyc - hs_cyc), N'(1));
        chal_valid = 1'b0;
        wait_done();
        pat = 5'b00111;
        for (int i = 0; i < 3; i++) begin
            send({4{32'h0F0F_0000 + 32'(i)}}, VOTE, VOTE ? 8'd3 : 8'd0);
            if (i > 0) chk("b2b_gap", N'(acc_cyc - hs_cyc), N'(1));
        end
        chal_valid = 1'b0;
        wait_done();
        send({4{32'hFFFF_0001}}, 1'b0, 8'd0);
        chal_valid = 1'b0;
        k = 0;
        while (!puf_in && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("settle_reached", N'(puf_in), N'(1));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_puf_in", N'(puf_in), N'(0));
        chk("mid_rst_puf_reset", N'(puf_reset), N'(1));
        chk("mid_rst_valid", N'(resp_valid), N'(0));
        chk("mid_rst_ready", N'(chal_ready), N'(0));
        chk("mid_rst_sel", puf_sel, '0);
        chk("mid_rst_ones", N'(resp_ones), N'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_mid_rst", N'(chal_ready), N'(1));
        pat = 5'b11111;
        send({4{32'h8000_0001}}, 1'b1, VOTE ? 8'd5 : 8'd1);
        chal_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
